// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: turns a command/response handshake into one AXI-Lite
// read or write transaction at a time, with saturating debug counters.
module axi_lite_cmd_master #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic [ADDR_WIDTH-1:0]   AW_ADDR,
    output logic [2:0]              AW_PROT,
    output logic                    AW_VALID,
    input  logic                    AW_READY,
    output logic [DATA_WIDTH-1:0]   W_DATA,
    output logic [DATA_WIDTH/8-1:0] W_STRB,
    output logic                    W_VALID,
    input  logic                    W_READY,
    input  logic [1:0]              B_RESP,
    input  logic                    B_valid,
    output logic                    B_ready,
    output logic [ADDR_WIDTH-1:0]   AR_ADDR,
    output logic [2:0]              AR_PROT,
    output logic                    AR_VALID,
    input  logic                    AR_READY,
    input  logic [DATA_WIDTH-1:0]   R_DATA,
    input  logic [1:0]              R_RESP,
    input  logic                    R_VALID,
    output logic                    R_READY,
    output logic [CNT_WIDTH-1:0]    wr_count,
    output logic [CNT_WIDTH-1:0]    rd_count,
    output logic [CNT_WIDTH-1:0]    err_count
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StWr, StWrResp, StRdAddr, StRdData, StRsp} state_e;

    state_e                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    aw_valid_q, aw_valid_d, w_valid_q, w_valid_d;
    logic                    aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic                    b_ready_q, b_ready_d, ar_valid_q, ar_valid_d, r_ready_q, r_ready_d;
    logic                    rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d, wdata_q, wdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [StrbWidth-1:0]    wstrb_q, wstrb_d;
    logic [CNT_WIDTH-1:0]    wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;
    logic                    aw_hs, w_hs;

    assign aw_hs = aw_valid_q & AW_READY;
    assign w_hs  = w_valid_q & W_READY;

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        b_ready_d   = b_ready_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_cnt_d   = err_cnt_q;
        unique case (state_q)
            StIdle: begin
                // cmd_ready comes up one cycle after reset release or response handshake
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    wstrb_d     = cmd_wstrb;
                    rsp_write_d = cmd_write;
                    if (cmd_write) begin
                        state_d    = StWr;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                        aw_done_d  = 1'b0;
                        w_done_d   = 1'b0;
                    end else begin
                        state_d    = StRdAddr;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            StWr: begin
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d   = StWrResp;
                    b_ready_d = 1'b1;
                end
            end
            StWrResp: begin
                if (B_valid && b_ready_q) begin
                    b_ready_d   = 1'b0;
                    rsp_resp_d  = B_RESP;
                    rsp_rdata_d = '0;
                    rsp_write_d = 1'b1;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRdAddr: begin
                if (AR_READY) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = StRdData;
                end
            end
            StRdData: begin
                if (R_VALID && r_ready_q) begin
                    r_ready_d   = 1'b0;
                    rsp_resp_d  = R_RESP;
                    rsp_rdata_d = R_DATA;
                    rsp_write_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = StRsp;
                end
            end
            StRsp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = StIdle;
                    // saturating counters
                    if (rsp_write_q && wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
                    if (!rsp_write_q && rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
                    if (rsp_resp_q != 2'b00 && err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            cmd_ready_q <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            b_ready_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            b_ready_q   <= b_ready_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;
    assign AW_ADDR   = addr_q;
    assign AW_PROT   = 3'b000;
    assign AW_VALID  = aw_valid_q;
    assign W_DATA    = wdata_q;
    assign W_STRB    = wstrb_q;
    assign W_VALID   = w_valid_q;
    assign B_ready   = b_ready_q;
    assign AR_ADDR   = addr_q;
    assign AR_PROT   = 3'b000;
    assign AR_VALID  = ar_valid_q;
    assign R_READY   = r_ready_q;
    assign wr_count  = wr_cnt_q;
    assign rd_count  = rd_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: directed scenarios plus randomized traffic against a
// memory-backed slave and a transaction-level reference model.
module tb_axi_lite_cmd_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic        cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
    logic [9:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_ready, rsp_valid, rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [9:0]  AW_ADDR, AR_ADDR;
    logic [2:0]  AW_PROT, AR_PROT;
    logic        AW_VALID, W_VALID, B_ready, AR_VALID, R_READY;
    logic [31:0] W_DATA;
    logic [3:0]  W_STRB;
    logic        AW_READY = 1'b0, W_READY = 1'b0, B_valid = 1'b0, AR_READY = 1'b0;
    logic        R_VALID = 1'b0;
    logic [1:0]  B_RESP = '0, R_RESP = '0;
    logic [31:0] R_DATA = '0;
    logic [15:0] wr_count, rd_count, err_count;

    // Narrow-counter instance fed the same inputs; only its counters are checked.
    logic        s_cmd_ready, s_rsp_valid, s_rsp_write, s_awv, s_wv, s_bready, s_arv, s_rready;
    logic [31:0] s_rsp_rdata, s_wdata;
    logic [1:0]  s_rsp_resp;
    logic [9:0]  s_awaddr, s_araddr;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_wr_count, s_rd_count, s_err_count;

    axi_lite_cmd_master u_dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .AW_ADDR(AW_ADDR), .AW_PROT(AW_PROT), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_valid(B_valid), .B_ready(B_ready),
        .AR_ADDR(AR_ADDR), .AR_PROT(AR_PROT), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY),
        .wr_count(wr_count), .rd_count(rd_count), .err_count(err_count)
    );

    axi_lite_cmd_master #(.CNT_WIDTH(2)) u_sat (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_write(s_rsp_write), .rsp_rdata(s_rsp_rdata), .rsp_resp(s_rsp_resp),
        .AW_ADDR(s_awaddr), .AW_PROT(s_awprot), .AW_VALID(s_awv), .AW_READY(AW_READY),
        .W_DATA(s_wdata), .W_STRB(s_wstrb), .W_VALID(s_wv), .W_READY(W_READY),
        .B_RESP(B_RESP), .B_valid(B_valid), .B_ready(s_bready),
        .AR_ADDR(s_araddr), .AR_PROT(s_arprot), .AR_VALID(s_arv), .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(s_rready),
        .wr_count(s_wr_count), .rd_count(s_rd_count), .err_count(s_err_count)
    );

    int n_cmp = 0, n_fail = 0;

    // Slave knobs (written by the main sequence only)
    bit         rand_rdy = 1'b0;
    int         w_lag = 0, b_lat = 0, r_lat = 0;
    logic [1:0] err_resp = 2'b00;

    // Reference model state
    logic [31:0] model_mem [256];
    logic [31:0] slv_mem [256];
    int          exp_wr = 0, exp_rd = 0, exp_err = 0;
    logic        exp_write;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_fail++;
        $error("FAIL %s: observed timeout expected event", tag);
    endtask

    // Memory slave; all decisions taken on the falling edge from values seen one edge earlier.
    logic       p_awv, p_wv, p_arv, p_bready, p_rready;
    logic [9:0] p_awaddr, p_araddr, q_awaddr, q_araddr;
    logic [31:0] p_wdata, q_wdata;
    logic [3:0] p_wstrb, q_wstrb;
    bit         aw_got, w_got, ar_got;
    int         wl, bl, rl;

    initial begin
        for (int i = 0; i < 256; i++) begin
            slv_mem[i]   = '0;
            model_mem[i] = '0;
        end
        {p_awv, p_wv, p_arv, p_bready, p_rready, aw_got, w_got, ar_got} = '0;
        wl = 0; bl = 0; rl = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                {AW_READY, W_READY, AR_READY, B_valid, R_VALID} = '0;
                {aw_got, w_got, ar_got} = '0;
                wl = 0; bl = 0; rl = 0;
            end else begin
                if (p_awv && AW_READY) begin q_awaddr = p_awaddr; aw_got = 1; wl = 0; end
                if (p_wv && W_READY) begin q_wdata = p_wdata; q_wstrb = p_wstrb; w_got = 1; end
                if (p_arv && AR_READY) begin q_araddr = p_araddr; ar_got = 1; rl = 0; end
                if (B_valid && p_bready) B_valid = 1'b0;
                if (R_VALID && p_rready) R_VALID = 1'b0;
                if (aw_got && w_got && !B_valid) begin
                    if (bl >= b_lat) begin
                        if (err_resp == 2'b00)
                            slv_mem[q_awaddr[9:2]] = merge(slv_mem[q_awaddr[9:2]], q_wdata, q_wstrb);
                        B_RESP = err_resp; B_valid = 1'b1; aw_got = 0; w_got = 0; bl = 0;
                    end else bl++;
                end
                if (ar_got && !R_VALID) begin
                    if (rl >= r_lat) begin
                        R_DATA = slv_mem[q_araddr[9:2]]; R_RESP = err_resp; R_VALID = 1'b1;
                        ar_got = 0; rl = 0;
                    end else rl++;
                end
                if (aw_got && !w_got) wl++;
                AW_READY = !aw_got && (!rand_rdy || $urandom_range(0, 1) == 1);
                AR_READY = !ar_got && (!rand_rdy || $urandom_range(0, 1) == 1);
                if (w_lag > 0) W_READY = !w_got && aw_got && (wl >= w_lag);
                else W_READY = !w_got && (!rand_rdy || $urandom_range(0, 1) == 1);
            end
            p_awv = AW_VALID; p_awaddr = AW_ADDR; p_wv = W_VALID; p_wdata = W_DATA;
            p_wstrb = W_STRB; p_arv = AR_VALID; p_araddr = AR_ADDR;
            p_bready = B_ready; p_rready = R_READY;
        end
    end

    // Presents one command and returns on the falling edge after it was accepted.
    task automatic issue(input logic wr, input logic [9:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        bit ok = 0;
        exp_write = wr;
        exp_resp  = err_resp;
        if (wr) begin
            exp_rdata = '0;
            if (err_resp == 2'b00) model_mem[a[9:2]] = merge(model_mem[a[9:2]], d, s);
        end else exp_rdata = model_mem[a[9:2]];
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        for (int i = 0; i < 50 && !ok; i++) begin
            if (cmd_ready) ok = 1;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        if (!ok) timeout("accept");
        else check("cmd_ready_drop", cmd_ready, 1'b0);
    endtask

    // Waits for the response, optionally stalls it while poking cmd_valid, then consumes it.
    task automatic complete(input int hold);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (rsp_valid) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            timeout("rsp_valid");
            return;
        end
        check("rsp_write", rsp_write, exp_write);
        check("rsp_rdata", rsp_rdata, exp_rdata);
        check("rsp_resp", rsp_resp, exp_resp);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 10'h3F0;
            cmd_wdata = 32'hBAD0BAD0; cmd_wstrb = 4'hF;
            @(negedge clk);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_rdata", rsp_rdata, exp_rdata);
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (exp_write) exp_wr++; else exp_rd++;
        if (exp_resp != 2'b00) exp_err++;
        check("rsp_valid_drop", rsp_valid, 1'b0);
        check("cmd_ready_rise", cmd_ready, 1'b1);
        check("wr_count", wr_count, sat(exp_wr, 65535));
        check("rd_count", rd_count, sat(exp_rd, 65535));
        check("err_count", err_count, sat(exp_err, 65535));
        check("sat_wr_count", s_wr_count, sat(exp_wr, 3));
        check("sat_rd_count", s_rd_count, sat(exp_rd, 3));
        check("sat_err_count", s_err_count, sat(exp_err, 3));
    endtask

    initial begin
        logic [31:0] wd;
        bit          ok;
        int          aw_hi;

        repeat (3) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_valids", {AW_VALID, W_VALID, AR_VALID, B_ready, R_READY, rsp_valid}, 6'b0);
        check("rst_counts", {wr_count, rd_count, err_count}, 48'b0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1'b1);

        // Write then read back
        issue(1'b1, 10'h004, 32'hDEADBEEF, 4'hF);
        check("aw_valid_lat1", {AW_VALID, W_VALID, AW_PROT}, {2'b11, 3'b000});
        complete(0);
        issue(1'b0, 10'h004, 32'h0, 4'h0);
        check("ar_valid_lat1", {AR_VALID, AR_ADDR, AR_PROT}, {1'b1, 10'h004, 3'b000});
        complete(0);
        check("readback_literal", rsp_rdata, 32'hDEADBEEF);

        // Skewed write: W_READY held off after the AW handshake
        w_lag = 3;
        issue(1'b1, 10'h010, 32'h12345678, 4'hF);
        aw_hi = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (AW_VALID) aw_hi++;
            if (!W_VALID) ok = 1;
            else begin
                check("skew_wdata_stable", W_DATA, 32'h12345678);
                check("skew_bready_low", B_ready, 1'b0);
                @(negedge clk);
            end
        end
        if (!ok) timeout("skew_w_handshake");
        check("skew_aw_cycles", aw_hi, 1);
        check("skew_bready_after_w", B_ready, 1'b1);
        complete(0);
        w_lag = 0;

        // Response backpressure on a read of 0x100
        issue(1'b1, 10'h100, 32'h00000100, 4'hF);
        complete(0);
        issue(1'b0, 10'h100, 32'h0, 4'h0);
        complete(4);

        // Error response
        err_resp = 2'b10;
        issue(1'b1, 10'h3FC, 32'hCAFEF00D, 4'hF);
        complete(0);
        err_resp = 2'b00;

        // Reset while waiting for read data
        r_lat = 6;
        issue(1'b0, 10'h004, 32'h0, 4'h0);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (R_READY) ok = 1;
            else @(negedge clk);
        end
        if (!ok) timeout("rd_data_state");
        rst = 1'b0;
        #1;
        check("midrst_valids", {AR_VALID, R_READY, rsp_valid, cmd_ready}, 4'b0);
        check("midrst_counts", {wr_count, rd_count, err_count, s_wr_count}, 50'b0);
        exp_wr = 0; exp_rd = 0; exp_err = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        r_lat = 0;
        @(negedge clk);
        check("midrst_cmd_ready", cmd_ready, 1'b1);
        issue(1'b1, 10'h008, 32'h00000008, 4'hF);
        complete(0);
        issue(1'b0, 10'h008, 32'h0, 4'h0);
        complete(0);

        // Saturation of the narrow counters
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, 10'h020, 32'h100 + i, 4'hF);
            complete(0);
        end
        check("sat_wr_stop", s_wr_count, 2'd3);

        // Randomized traffic
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            b_lat = $urandom_range(0, 3);
            r_lat = $urandom_range(0, 3);
            err_resp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3)) : 2'b00;
            wd = $urandom;
            issue(1'($urandom_range(0, 1)), {5'($urandom_range(0, 7)), 3'b0, 2'b00} |
                  (($urandom_range(0, 1) == 1) ? 10'h3E0 : 10'h000), wd, 4'($urandom_range(0, 15)));
            complete($urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
